// File: rtl/axis_stream_tx.sv
// axis_stream_tx
// AXI4-Stream master transmitter. Words written by the core through the
// osif_* FIFO-style interface are buffered in a small register FIFO and
// driven out as AXIS beats. TLAST comes from the core's last flag or from a
// programmed packet length (auto-last).
//
// Ports:
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   osif_*_din            write payload {data, strb, last, user}
//   osif_write            write strobe, accepted when osif_full_n=1
//   osif_full_n           1 = FIFO can accept a word this cycle
//   pkt_len               beats per packet for auto-last, 0 disables it
//   TVALID..TUSER, TREADY AXIS master interface
//   overflow              sticky, write attempted while full
//   beat_cnt              beats sent in the current packet
//
// Every output is a register. The next-cycle values of the FIFO flags, the
// head entry and TLAST are computed from the next pointer/counter state, so
// the outputs always describe the state the FIFO is in this cycle.

module axis_stream_tx #(
  parameter int unsigned TBITS = 64,
  parameter int unsigned TBYTE = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LENW  = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [TBITS-1:0] osif_data_din,
  input  logic [TBYTE-1:0] osif_strb_din,
  input  logic             osif_last_din,
  input  logic             osif_user_din,
  input  logic             osif_write,
  output logic             osif_full_n,
  input  logic [LENW-1:0]  pkt_len,
  output logic             TVALID,
  input  logic             TREADY,
  output logic [TBITS-1:0] TDATA,
  output logic [TBYTE-1:0] TKEEP,
  output logic             TLAST,
  output logic             TUSER,
  output logic             overflow,
  output logic [LENW-1:0]  beat_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [TBITS-1:0] data;
    logic [TBYTE-1:0] strb;
    logic             last;
    logic             user;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            r_full_n;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_overflow;
  entry_t          r_head;
  logic [LENW-1:0] r_beat_cnt;
  logic [LENW-1:0] r_len_q;

  entry_t          w_wr_entry;
  entry_t          w_head_nxt;
  logic            w_wr_en;
  logic            w_hs;
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic            w_empty_nxt;
  logic            w_full_nxt;
  logic [LENW-1:0] w_cnt_nxt;
  logic [LENW-1:0] w_len_nxt;
  logic            w_tlast_nxt;

  // Next-state computation for pointers, head entry, packet counter and TLAST
  always_comb begin
    w_wr_entry   = '{data: osif_data_din, strb: osif_strb_din,
                     last: osif_last_din, user: osif_user_din};
    w_wr_en      = osif_write & r_full_n;
    w_hs         = r_tvalid & TREADY;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_head_nxt   = '0;
    w_len_nxt    = r_len_q;
    w_cnt_nxt    = r_beat_cnt;
    w_tlast_nxt  = 1'b0;

    if (w_wr_en) w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    if (w_hs)    w_rd_ptr_nxt = r_rd_ptr + PW'(1);

    w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    w_full_nxt  = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                  (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);

    // The new head is the word being written when everything older drains
    if (!w_empty_nxt) begin
      if (w_wr_en && (w_rd_ptr_nxt == r_wr_ptr)) w_head_nxt = w_wr_entry;
      else                                       w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
    end

    // Packet length only tracks pkt_len between packets
    if ((r_beat_cnt == '0) && !w_hs) w_len_nxt = pkt_len;

    if (w_hs) w_cnt_nxt = r_tlast ? '0 : r_beat_cnt + LENW'(1);

    w_tlast_nxt = !w_empty_nxt &&
                  (w_head_nxt.last ||
                   ((w_len_nxt != '0) && (w_cnt_nxt == w_len_nxt - LENW'(1))));
  end

  // Storage array, written at the tail
  always_ff @(posedge ACLK) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
  end

  // Pointers, flags, output stage and packet state
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_full_n   <= 1'b1;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_overflow <= 1'b0;
      r_head     <= '0;
      r_beat_cnt <= '0;
      r_len_q    <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_full_n   <= !w_full_nxt;
      r_tvalid   <= !w_empty_nxt;
      r_tlast    <= w_tlast_nxt;
      r_head     <= w_head_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_len_q    <= w_len_nxt;
      if (osif_write && !r_full_n) r_overflow <= 1'b1;
    end
  end

  assign osif_full_n = r_full_n;
  assign TVALID      = r_tvalid;
  assign TDATA       = r_head.data;
  assign TKEEP       = r_head.strb;
  assign TLAST       = r_tlast;
  assign TUSER       = r_head.user;
  assign overflow    = r_overflow;
  assign beat_cnt    = r_beat_cnt;

endmodule

// File: doc/axis_stream_tx.md
Name: axis_stream_tx

Overview:
- AXI4-Stream transmitter: the master-side counterpart to the accelerator's input stream receiver.
- Accepts words from the core through a FIFO-style write interface (osif_*), buffers them in a small register FIFO, and drives them out as AXIS beats.
- Generates TLAST from the core's last flag, or from a programmed packet length (auto-last).
- Sits between the core's output path and the S2MM DMA, or feeds the MM2S port in loopback benches.

Parameters:
- TBITS, 64, TDATA width in bits.
- TBYTE, 8, TKEEP width (TBITS/8).
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- LENW, 16, width of the packet-length input and beat counter.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- osif_data_din  in  TBITS  write data.
- osif_strb_din  in  TBYTE  byte strobes, sent out as TKEEP.
- osif_last_din  in  1  explicit end-of-packet flag.
- osif_user_din  in  1  sideband, sent out as TUSER.
- osif_write  in  1  write strobe; accepted only when osif_full_n=1.
- osif_full_n  out  1  1 = FIFO can accept a word this cycle.
- pkt_len  in  LENW  beats per packet for auto-last; 0 disables auto-last.
- TVALID  out  1  AXIS valid.
- TREADY  in  1  AXIS ready.
- TDATA  out  TBITS  AXIS data.
- TKEEP  out  TBYTE  AXIS keep.
- TLAST  out  1  AXIS last.
- TUSER  out  1  AXIS user.
- overflow  out  1  sticky; set on a write attempted while full.
- beat_cnt  out  LENW  beats sent in the current packet.

Behaviour:
- Reset (ARESETN=0, async assert, sync release):
  - FIFO empty; TVALID=0, TLAST=0, overflow=0, beat_cnt=0.
  - osif_full_n=1 in the first cycle after release.
  - TDATA, TKEEP and TUSER read 0 while empty.
- Storage:
  - DEPTH-entry register array with wr_ptr/rd_ptr of log2(DEPTH)+1 bits.
  - full = pointer MSBs differ and low bits equal; empty = pointers equal.
- Write: when osif_write=1 and osif_full_n=1, store {data, strb, last, user} at wr_ptr and increment wr_ptr.
- Write while full (osif_write=1, osif_full_n=0):
  - The word is dropped and pointers are unchanged.
  - overflow is set and stays set until reset.
- osif_full_n is the registered !full; there is no bypass of a full FIFO, even when a read happens in the same cycle.
- Read/output:
  - TVALID = !empty; TDATA, TKEEP and TUSER come from the head entry.
  - A handshake (TVALID & TREADY) increments rd_ptr.
  - Once TVALID=1, the head is held stable until the handshake (AXIS rule).
- Latency: a word written in cycle N is visible on TVALID/TDATA in cycle N+1.
- Throughput: simultaneous write and read in the same cycle are both performed, count unchanged; one beat per cycle is sustained with TREADY=1.
- Empty FIFO plus a write in the same cycle: TVALID stays 0 that cycle (no combinational bypass).
- Auto-last:
  - len_q latches pkt_len whenever beat_cnt=0 and no handshake occurs that cycle; it is frozen mid-packet.
  - TLAST = head.last OR (len_q!=0 AND beat_cnt==len_q-1), qualified by TVALID.
  - beat_cnt increments on each handshake and clears to 0 on a handshake with TLAST=1.
  - len_q=1: every beat is last.
  - beat_cnt wraps modulo 2^LENW when auto-last is disabled and no explicit last arrives.
- Explicit last from the core ends the packet early; the counter restarts.
- Reset mid-packet: FIFO contents are discarded, beat_cnt and len_q clear, and TVALID drops asynchronously.

Test Plan:
- Basic: write 0x11..0x44 with TREADY=1 and pkt_len=0 -> four beats in order, first TVALID one cycle after the first write, TKEEP=0xFF, TLAST only where osif_last_din=1.
- Backpressure/full: TREADY=0, write 5 words (DEPTH=4) -> osif_full_n=0 after the 4th, 5th dropped, overflow=1. Then raise TREADY -> exactly 4 beats, TDATA stable throughout the stall.
- Auto-last: pkt_len=3, stream 7 words -> TLAST on beats 3 and 6, beat_cnt sequence 0,1,2,0,1,2,0. Changing pkt_len to 5 mid-packet has no effect until beat_cnt=0.
- Explicit last overrides: pkt_len=4 and osif_last_din=1 on the 2nd word -> TLAST on beat 2, next packet TLAST after 4 more beats.
- Concurrent read/write: full FIFO, TREADY=1, continuous writes each time osif_full_n=1 -> no overflow, no beat loss or duplication, 1 beat per cycle once steady.
- Reset mid-packet: assert ARESETN=0 after 2 of 3 beats -> TVALID=0 immediately. After release, osif_full_n=1, beat_cnt=0, and the next packet starts clean.
